// File: rtl/periph_bridge_pkg.sv
// Shared types for the OBI to register-bus peripheral bridge: bus structs,
// FSM states, error codes and the default error read data.
package periph_bridge_pkg;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DEC  = 2'd1,
    REG  = 2'd2,
    TMO  = 2'd3
  } err_code_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Matches when start_addr <= addr < end_addr.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/periph_bridge_wdog.sv
// Access watchdog: cleared before each access, counts enabled cycles and
// saturates; expires on the last permitted cycle. Disabled when the limit is 0.
module periph_bridge_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign o_expire = 1'b0;
  end else begin : g_on
    assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/periph_regbus_bridge.sv
// OBI slave to N-port register-bus bridge: runtime address decode, one
// transaction in flight, watchdog-bounded accesses and a sticky first-error record.
module periph_regbus_bridge
  import periph_bridge_pkg::*;
#(
  parameter int unsigned NPORTS         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  input  rule_t       addr_map_i   [NPORTS],
  output reg_req_t    periph_req_o [NPORTS],
  input  reg_rsp_t    periph_rsp_i [NPORTS],
  input  logic        err_clr_i,
  output logic        err_valid_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_e           r_state;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  logic [3:0]       r_be;
  logic [IDX_W-1:0] r_idx;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_err_valid;
  err_code_e        r_err_code;
  logic [31:0]      r_err_addr;

  logic             w_gnt;
  logic             w_acc;
  logic             w_dec_hit;
  logic [IDX_W-1:0] w_dec_idx;
  reg_rsp_t         w_rsp;
  logic             w_expire;
  logic             w_ok;
  logic             w_done;
  logic             w_err;
  err_code_e        w_code;

  assign w_gnt = slave_req_i.req && (r_state == IDLE);
  assign w_acc = (r_state == ACCESS);
  assign w_rsp = periph_rsp_i[r_idx];

  // Later matching rules override earlier ones; out-of-range port indices miss.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if ((r_addr >= addr_map_i[i].start_addr) && (r_addr < addr_map_i[i].end_addr) &&
          (addr_map_i[i].idx < NPORTS)) begin
        w_dec_hit = 1'b1;
        w_dec_idx = addr_map_i[i].idx[IDX_W-1:0];
      end
    end
  end

  periph_bridge_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clr   (r_state == DECODE),
    .i_en    (w_acc),
    .o_expire(w_expire)
  );

  always_comb begin
    w_ok   = w_acc && w_rsp.ready && !w_rsp.error;
    w_code = NONE;
    if ((r_state == DECODE) && !w_dec_hit) begin
      w_code = DEC;
    end else if (w_acc && w_rsp.ready && w_rsp.error) begin
      w_code = REG;
    end else if (w_acc && !w_rsp.ready && w_expire) begin
      w_code = TMO;
    end
    w_err  = (w_code != NONE);
    w_done = w_ok || w_err;
  end

  // The response phase lives in r_rvalid; the FSM is already back in IDLE
  // during that cycle so a waiting request is granted alongside rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_idx    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_done;
      if (w_done) begin
        r_rdata <= w_ok ? (r_we ? '0 : w_rsp.rdata) : ERR_RDATA;
      end
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_addr  <= slave_req_i.addr;
            r_wdata <= slave_req_i.wdata;
            r_we    <= slave_req_i.we;
            r_be    <= slave_req_i.be;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_dec_hit) begin
            r_idx   <= w_dec_idx;
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (w_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_code  <= NONE;
      r_err_addr  <= '0;
    end else if (w_err && (!r_err_valid || err_clr_i)) begin
      r_err_valid <= 1'b1;
      r_err_code  <= w_code;
      r_err_addr  <= r_addr;
    end else if (err_clr_i) begin
      r_err_valid <= 1'b0;
      r_err_code  <= NONE;
      r_err_addr  <= '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      periph_req_o[i].addr  = r_addr;
      periph_req_o[i].write = r_we;
      periph_req_o[i].wdata = r_wdata;
      periph_req_o[i].wstrb = r_be;
      periph_req_o[i].valid = w_acc && (r_idx == IDX_W'(i));
    end
  end

  assign slave_resp_o.gnt    = w_gnt;
  assign slave_resp_o.rvalid = r_rvalid;
  assign slave_resp_o.rdata  = r_rdata;
  assign err_valid_o         = r_err_valid;
  assign err_code_o          = r_err_code;
  assign err_addr_o          = r_err_addr;

endmodule
